// File: rtl/regular_fuzzification_engine.sv
// regular_fuzzification_engine: latches NUM_INPUTS crisp inputs on start and streams
// one triangular membership degree per (channel, set) pair over a valid/ready handshake.
module regular_fuzzification_engine #(
  parameter int WIDTH      = 10,
  parameter int NUM_INPUTS = 2,
  parameter int NUM_SETS   = 5,
  parameter int MU_WIDTH   = 8,
  localparam int SET_W     = $clog2(NUM_SETS),
  localparam int CH_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_start,
  input  logic [NUM_INPUTS*WIDTH-1:0] io_input,
  input  logic                        io_cfgWrite,
  input  logic [SET_W-1:0]            io_cfgSet,
  input  logic [WIDTH-1:0]            io_cfgCenter,
  input  logic [3:0]                  io_cfgShift,
  output logic                        io_busy,
  output logic                        io_outValid,
  input  logic                        io_outReady,
  output logic [CH_W-1:0]             io_outChannel,
  output logic [SET_W-1:0]            io_outSet,
  output logic [MU_WIDTH-1:0]         io_outMu,
  output logic                        io_outLast,
  output logic                        io_done
);

  localparam int E_W  = WIDTH + 15;
  localparam int STEP = (2 ** WIDTH) / NUM_SETS;
  localparam logic [E_W-1:0]   MU_MAX_E = E_W'((2 ** MU_WIDTH) - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(NUM_SETS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_input  [NUM_INPUTS];
  logic [WIDTH-1:0]   r_center [NUM_SETS];
  logic [3:0]         r_shift  [NUM_SETS];
  logic [CH_W-1:0]    r_ch;
  logic [SET_W-1:0]   r_set;

  logic               w_lastBeat;
  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_c;
  logic [WIDTH-1:0]   w_d;
  logic [E_W-1:0]     w_e;
  logic [MU_WIDTH-1:0] w_mu;

  // Membership uses only latched inputs and config registers, so the payload
  // never depends combinationally on io_input or io_cfg*.
  always_comb begin
    w_x  = r_input[r_ch];
    w_c  = r_center[r_set];
    w_d  = (w_x >= w_c) ? (w_x - w_c) : (w_c - w_x);
    w_e  = E_W'(w_d) << r_shift[r_set];
    w_mu = (w_e >= MU_MAX_E) ? '0 : MU_WIDTH'(MU_MAX_E - w_e);
  end

  assign w_lastBeat    = (r_ch == CH_LAST) && (r_set == SET_LAST);
  assign io_busy       = (r_state == EVAL);
  assign io_outValid   = (r_state == EVAL);
  assign io_outLast    = io_outValid && w_lastBeat;
  assign io_done       = (r_state == DONE);
  assign io_outChannel = io_outValid ? r_ch  : '0;
  assign io_outSet     = io_outValid ? r_set : '0;
  assign io_outMu      = io_outValid ? w_mu  : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_set   <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_input[i] <= '0;
      end
      for (int s = 0; s < NUM_SETS; s++) begin
        r_center[s] <= WIDTH'(s * STEP);
        r_shift[s]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          // A same-cycle config write lands at this edge, so a frame started now sees it.
          if (io_cfgWrite && (int'(io_cfgSet) < NUM_SETS)) begin
            r_center[io_cfgSet] <= io_cfgCenter;
            r_shift[io_cfgSet]  <= io_cfgShift;
          end
          if (io_start) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              r_input[i] <= io_input[i*WIDTH +: WIDTH];
            end
            r_ch    <= '0;
            r_set   <= '0;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          if (io_outReady) begin
            if (w_lastBeat) begin
              r_state <= DONE;
            end else if (r_set == SET_LAST) begin
              r_set <= '0;
              r_ch  <= r_ch + CH_W'(1);
            end else begin
              r_set <= r_set + SET_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regular_fuzzification_engine.md
# regular_fuzzification_engine

Parametrised fuzzifier for the online fuzzy datapath. On a start pulse it latches `NUM_INPUTS` crisp inputs and streams one membership degree per (input, fuzzy set) pair through a valid/ready handshake. Each set is a symmetric triangle with a programmable center and slope shift. It replaces the fixed two-input regular fuzzification stage and feeds the rule/inference stage downstream.

## Interface
Parameters:
- `WIDTH`, 10: crisp input width (unsigned).
- `NUM_INPUTS`, 2: number of input channels; ≥1.
- `NUM_SETS`, 5: fuzzy sets per channel, shared by all channels; ≥2.
- `MU_WIDTH`, 8: membership width; `MU_MAX = 2^MU_WIDTH-1`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `io_start`  in  1  start pulse; honoured only in IDLE.
- `io_input`  in  `NUM_INPUTS*WIDTH`  packed inputs, channel 0 in LSBs.
- `io_cfgWrite`  in  1  config write strobe; honoured only in IDLE.
- `io_cfgSet`  in  `clog2(NUM_SETS)`  set index written; index ≥ `NUM_SETS` is ignored.
- `io_cfgCenter`  in  `WIDTH`  new center.
- `io_cfgShift`  in  4  new slope shift.
- `io_busy`  out  1  high in EVAL.
- `io_outValid`  out  1  membership beat valid.
- `io_outReady`  in  1  downstream accept.
- `io_outChannel`  out  `clog2(NUM_INPUTS)` (min 1)  channel of the beat.
- `io_outSet`  out  `clog2(NUM_SETS)`  set of the beat.
- `io_outMu`  out  `MU_WIDTH`  membership degree.
- `io_outLast`  out  1  final beat of the frame.
- `io_done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- Config regs, per set: `center[s]` (WIDTH) and `shift[s]` (4).
  - Reset value: `center[s] = s*STEP` with `STEP = 2^WIDTH / NUM_SETS` (integer division).
  - Reset value: `shift[s] = 0`.
  - A write in IDLE updates `center[s]` and `shift[s]` at the next edge.
  - A write in EVAL is dropped.
- Membership for input x and set s:
  - `d = |x - center[s]|`, computed exactly, WIDTH bits.
  - `e = d << shift[s]`, computed in WIDTH+15 bits, no truncation.
  - `mu = (e >= MU_MAX) ? 0 : MU_MAX - e`.
- FSM states:
  - IDLE: when `io_start` is high, latch all of `io_input`, clear `ch` and `set` counters, go to EVAL.
  - EVAL: `io_outValid` = 1 and the payload is the (`ch`, `set`) pair, computed from latched input and config regs only. No combinational path from `io_input` or `io_cfg*` to outputs.
    - On `io_outValid & io_outReady`: advance `set`. At `set = NUM_SETS-1`, wrap `set` to 0 and increment `ch`.
    - Order: channel-major, set-minor.
  - `io_outLast` = 1 when `ch = NUM_INPUTS-1` and `set = NUM_SETS-1`. Acceptance of that beat moves the FSM to DONE.
  - DONE: `io_done` = 1 for exactly one cycle, then IDLE.
- Frame length is exactly `NUM_INPUTS*NUM_SETS` beats.
- `io_start` in EVAL or DONE is ignored (no queuing).
- `io_input` changes after the latch do not affect the current frame.
- With `io_outReady` low, payload and counters hold stable.

## Timing
- Reset: FSM to IDLE; `io_busy`, `io_outValid`, `io_outLast`, `io_done` = 0; `io_outChannel`, `io_outSet`, `io_outMu` = 0; config regs to defaults.
- `reset` asserted mid-frame aborts immediately, with no `io_done`.
- `io_start` sampled high at edge T:
  - `io_busy` and `io_outValid` are high from T+1.
  - First beat can transfer in cycle T+1.
- Full throughput: one beat per cycle while ready.
  - Final beat transfers in cycle T+`NUM_INPUTS*NUM_SETS`.
  - `io_done` pulses in the following cycle.
  - Earliest next start is sampled in the cycle after `io_done`.
- A start and a config write in the same IDLE cycle both take effect; the frame uses the new config.

## Test plan
- Defaults (10/2/5/8, centers 0,204,408,612,816), inputs x0=204, x1=1000, ready always high:
  - ch0 mu = 51,255,51,0,0.
  - ch1 mu = 0,0,0,0,71.
  - `io_outLast` only on beat 10; `io_done` on the cycle after.
- Write set 2 center=500 shift=2, then start with x0=510 → ch0 set2 mu=215.
- Shift=4, d=16 → e=256 ≥ 255 → mu=0.
- Ready pattern 1,0,0,1 repeating → sequence identical to the full-throughput run; payload stable across stall cycles.
- `io_start` and a config write (set 1 center=0) during EVAL:
  - Start is ignored; no second frame follows.
  - The current frame uses old centers.
  - A next frame shows set 1 unchanged.
- `reset` at beat 4:
  - All outputs are 0 next cycle; no `io_done`.
  - A fresh start yields the full 10-beat frame from (0,0).
